// File: rtl/hqm_rcfwl_gclk_rcb_multi_seq.sv
// Multi-channel regional clock buffer controller.
// Converts per-channel regional power-enable requests into staggered,
// hysteresis-held RCB enables and gates the inverted grid clock per channel.

// Behavioural ctech RCB AND: enable latch, transparent while the grid clock is
// high, ANDed with the inverted grid clock so the output never glitches.
module hqm_rcfwl_gclk_ctech_rcb_and (
    input  logic i_ck,
    input  logic i_en,
    input  logic i_fd,
    input  logic i_rd,
    output logic o_ck
);
    logic r_en_lat;
    logic w_unused_trim;

    // fd/rd are LCP trim bits for the physical cell; they have no logical effect
    assign w_unused_trim = i_fd ^ i_rd;

    // Capture the enable during the high grid phase so the low phase pulse is clean
    always_latch begin
        if (i_ck) begin
            r_en_lat <= i_en;
        end
    end

    assign o_ck = (~i_ck) & r_en_lat;
endmodule

module hqm_rcfwl_gclk_rcb_multi_seq #(
    parameter int NUM_CH      = 4,
    parameter int HYST_W      = 6,
    parameter int STAGGER_CYC = 2
) (
    input  logic              CkGridX1N,
    input  logic              RstB,
    input  logic [NUM_CH-1:0] RPEn,
    input  logic              RPOvrd,
    input  logic              FscanClkUngate,
    input  logic [HYST_W-1:0] HystCnt,
    input  logic [NUM_CH-1:0] Fd,
    input  logic [NUM_CH-1:0] Rd,
    output logic [NUM_CH-1:0] CkRcbX2NB,
    output logic [NUM_CH-1:0] RcbEnAck,
    output logic              WakePend
);
    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_WAKE = 2'd1;
    localparam logic [1:0] ST_ON   = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam int               STG_W    = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
    localparam logic [STG_W-1:0] STG_LOAD = STG_W'(STAGGER_CYC - 1);
    localparam logic [STG_W-1:0] STG_ONE  = STG_W'(1);
    localparam logic [HYST_W-1:0] CNT_ONE = HYST_W'(1);

    logic [1:0]        r_state     [NUM_CH];
    logic [1:0]        w_state_nxt [NUM_CH];
    logic [HYST_W-1:0] r_cnt       [NUM_CH];
    logic [HYST_W-1:0] w_cnt_nxt   [NUM_CH];
    logic [STG_W-1:0]  r_stag;
    logic [STG_W-1:0]  w_stag_nxt;
    logic [NUM_CH-1:0] w_cand;
    logic [NUM_CH-1:0] w_grant;
    logic [NUM_CH-1:0] w_ack_nxt;
    logic [NUM_CH-1:0] w_wake_nxt;
    logic [NUM_CH-1:0] w_en;
    logic [NUM_CH-1:0] r_ack;
    logic              r_wake;

    // Arbiter: requesting OFF/WAKE channels compete; lowest index wins when the stagger window is clear
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cand[i] = RPEn[i] & ((r_state[i] == ST_OFF) | (r_state[i] == ST_WAKE));
        end
        w_grant = w_cand & (~w_cand + NUM_CH'(1)) & {NUM_CH{r_stag == '0}};
    end

    // Stagger counter: reload on a grant, otherwise count down and hold at zero
    always_comb begin
        w_stag_nxt = r_stag;
        if (|w_grant) begin
            w_stag_nxt = STG_LOAD;
        end else if (r_stag != '0) begin
            w_stag_nxt = r_stag - STG_ONE;
        end else begin
            w_stag_nxt = r_stag;
        end
    end

    // Per-channel OFF/WAKE/ON/HOLD next-state and hold counter
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                ST_OFF: begin
                    if (w_grant[i])   w_state_nxt[i] = ST_ON;
                    else if (RPEn[i]) w_state_nxt[i] = ST_WAKE;
                    else              w_state_nxt[i] = ST_OFF;
                end
                ST_WAKE: begin
                    if (!RPEn[i])        w_state_nxt[i] = ST_OFF;
                    else if (w_grant[i]) w_state_nxt[i] = ST_ON;
                    else                 w_state_nxt[i] = ST_WAKE;
                end
                ST_ON: begin
                    if (RPEn[i]) begin
                        w_state_nxt[i] = ST_ON;
                    end else if (HystCnt == '0) begin
                        w_state_nxt[i] = ST_OFF;
                    end else begin
                        w_state_nxt[i] = ST_HOLD;
                        w_cnt_nxt[i]   = HystCnt;
                    end
                end
                ST_HOLD: begin
                    // Re-request resumes ON directly; it never touches the arbiter
                    if (RPEn[i]) begin
                        w_state_nxt[i] = ST_ON;
                    end else if (r_cnt[i] == CNT_ONE) begin
                        w_state_nxt[i] = ST_OFF;
                    end else begin
                        w_state_nxt[i] = ST_HOLD;
                        w_cnt_nxt[i]   = r_cnt[i] - CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_OFF;
                    w_cnt_nxt[i]   = '0;
                end
            endcase
            w_ack_nxt[i]  = (w_state_nxt[i] == ST_ON) | (w_state_nxt[i] == ST_HOLD);
            w_wake_nxt[i] = (w_state_nxt[i] == ST_WAKE);
        end
    end

    // State, counters and registered status outputs
    always_ff @(posedge CkGridX1N or negedge RstB) begin
        if (!RstB) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= ST_OFF;
                r_cnt[i]   <= '0;
            end
            r_stag <= '0;
            r_ack  <= '0;
            r_wake <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_stag <= w_stag_nxt;
            r_ack  <= w_ack_nxt;
            r_wake <= |w_wake_nxt;
        end
    end

    // Overrides force the clock on without disturbing the FSMs
    assign w_en     = r_ack | {NUM_CH{RPOvrd | FscanClkUngate}};
    assign RcbEnAck = r_ack;
    assign WakePend = r_wake;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_rcb
        hqm_rcfwl_gclk_ctech_rcb_and u_rcb_and (
            .i_ck (CkGridX1N),
            .i_en (w_en[g]),
            .i_fd (Fd[g]),
            .i_rd (Rd[g]),
            .o_ck (CkRcbX2NB[g])
        );
    end
endmodule

// File: tb/tb_hqm_rcfwl_gclk_rcb_multi_seq.sv
// Self-checking bench for hqm_rcfwl_gclk_rcb_multi_seq (NUM_CH=4, STAGGER_CYC=2).
// Reference model tracks, per channel, whether it is acknowledged and the edge
// at which a running hold expires, plus the edge of the last wake grant.
module tb_hqm_rcfwl_gclk_rcb_multi_seq;
    localparam int NUM_CH = 4;
    localparam int HYST_W = 6;
    localparam int STAG   = 2;

    logic              clk = 1'b0;
    logic              RstB;
    logic [NUM_CH-1:0] RPEn;
    logic              RPOvrd;
    logic              FscanClkUngate;
    logic [HYST_W-1:0] HystCnt;
    logic [NUM_CH-1:0] Fd;
    logic [NUM_CH-1:0] Rd;
    logic [NUM_CH-1:0] CkRcbX2NB;
    logic [NUM_CH-1:0] RcbEnAck;
    logic              WakePend;

    int n_vec = 0;
    int n_err = 0;

    logic [NUM_CH-1:0] m_ack;
    logic [NUM_CH-1:0] m_hold;
    int                m_hend [NUM_CH];
    int                m_edge;
    int                m_last;
    logic              m_wake;

    hqm_rcfwl_gclk_rcb_multi_seq #(.NUM_CH(NUM_CH), .HYST_W(HYST_W), .STAGGER_CYC(STAG)) dut (
        .CkGridX1N      (clk),
        .RstB           (RstB),
        .RPEn           (RPEn),
        .RPOvrd         (RPOvrd),
        .FscanClkUngate (FscanClkUngate),
        .HystCnt        (HystCnt),
        .Fd             (Fd),
        .Rd             (Rd),
        .CkRcbX2NB      (CkRcbX2NB),
        .RcbEnAck       (RcbEnAck),
        .WakePend       (WakePend)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ack  = '0;
        m_hold = '0;
        m_wake = 1'b0;
        m_edge = 0;
        m_last = -1000;
        for (int i = 0; i < NUM_CH; i++) m_hend[i] = 0;
    endtask

    task automatic model_edge();
        logic [NUM_CH-1:0] prev;
        logic [NUM_CH-1:0] req;
        prev = m_ack;
        req  = RPEn;
        m_edge++;
        for (int i = 0; i < NUM_CH; i++) begin
            if (prev[i]) begin
                if (req[i]) begin
                    m_hold[i] = 1'b0;
                end else if (!m_hold[i]) begin
                    if (HystCnt == 0) m_ack[i] = 1'b0;
                    else begin
                        m_hold[i] = 1'b1;
                        m_hend[i] = m_edge + int'(HystCnt);
                    end
                end else if (m_edge >= m_hend[i]) begin
                    m_ack[i]  = 1'b0;
                    m_hold[i] = 1'b0;
                end
            end
        end
        if (m_edge - m_last >= STAG) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!prev[i] && req[i] && m_last != m_edge) begin
                    m_ack[i] = 1'b1;
                    m_last   = m_edge;
                end
            end
        end
        m_wake = |(req & ~m_ack);
    endtask

    // One grid cycle: model follows the edge; returns 7 time units later (low phase)
    task automatic tick();
        @(posedge clk);
        if (!RstB) model_reset();
        else model_edge();
        #7;
    endtask

    function automatic logic [NUM_CH-1:0] exp_ck();
        return m_ack | {NUM_CH{RPOvrd | FscanClkUngate}};
    endfunction

    task automatic test_reset();
        RstB = 1'b0; RPEn = '0; RPOvrd = 1'b0; FscanClkUngate = 1'b0;
        HystCnt = 6'd3; Fd = '0; Rd = '0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++; if (RcbEnAck !== 4'h0) begin n_err++; $display("FAIL reset_ack got=%h exp=0", RcbEnAck); end
            n_vec++; if (WakePend !== 1'b0) begin n_err++; $display("FAIL reset_wake got=%b exp=0", WakePend); end
            n_vec++; if (CkRcbX2NB !== 4'h0) begin n_err++; $display("FAIL reset_ck got=%h exp=0", CkRcbX2NB); end
        end
        RstB = 1'b1;
    endtask

    task automatic test_stagger();
        logic [NUM_CH-1:0] tbl [8];
        tbl = '{4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF, 4'hF};
        RPEn = 4'hF;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_vec++; if (RcbEnAck !== tbl[e-1]) begin n_err++; $display("FAIL stagger_ack edge=%0d got=%h exp=%h", e, RcbEnAck, tbl[e-1]); end
            n_vec++; if (RcbEnAck !== m_ack) begin n_err++; $display("FAIL stagger_model edge=%0d got=%h exp=%h", e, RcbEnAck, m_ack); end
            n_vec++; if (WakePend !== (e < 7)) begin n_err++; $display("FAIL stagger_wake edge=%0d got=%b exp=%b", e, WakePend, (e < 7)); end
            n_vec++; if (CkRcbX2NB !== exp_ck()) begin n_err++; $display("FAIL stagger_ck edge=%0d got=%h exp=%h", e, CkRcbX2NB, exp_ck()); end
        end
    endtask

    task automatic test_hold();
        HystCnt = 6'd3;
        RPEn    = 4'hE;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_vec++; if (RcbEnAck[0] !== (k < 4)) begin n_err++; $display("FAIL hold_ack0 k=%0d got=%b exp=%b", k, RcbEnAck[0], (k < 4)); end
            n_vec++; if (RcbEnAck !== m_ack) begin n_err++; $display("FAIL hold_model k=%0d got=%h exp=%h", k, RcbEnAck, m_ack); end
            n_vec++; if (CkRcbX2NB !== exp_ck()) begin n_err++; $display("FAIL hold_ck k=%0d got=%h exp=%h", k, CkRcbX2NB, exp_ck()); end
        end
    endtask

    task automatic test_reenter();
        HystCnt = 6'd5;
        for (int k = 0; k < 5; k++) begin
            if (k < 2) RPEn = 4'hC;
            else if (k < 3) RPEn = 4'hE;
            else RPEn = 4'hF;
            tick();
            n_vec++; if (RcbEnAck[1] !== 1'b1) begin n_err++; $display("FAIL reenter_ack1 k=%0d got=%b exp=1", k, RcbEnAck[1]); end
            n_vec++; if (RcbEnAck !== m_ack) begin n_err++; $display("FAIL reenter_model k=%0d got=%h exp=%h", k, RcbEnAck, m_ack); end
        end
        // ch0 was raised the cycle right after ch1 re-entered: must be granted at once
        n_vec++; if (RcbEnAck !== 4'hF) begin n_err++; $display("FAIL reenter_nostag got=%h exp=f", RcbEnAck); end
    endtask

    task automatic test_override();
        RPEn = '0;
        for (int k = 0; k < 8; k++) tick();
        n_vec++; if (RcbEnAck !== 4'h0) begin n_err++; $display("FAIL ovr_idle got=%h exp=0", RcbEnAck); end
        for (int m = 0; m < 3; m++) begin
            RPOvrd = (m == 0); FscanClkUngate = (m == 1);
            for (int k = 0; k < 2; k++) begin
                tick();
                n_vec++; if (CkRcbX2NB !== ((m < 2) ? 4'hF : 4'h0)) begin n_err++; $display("FAIL ovr_ck m=%0d got=%h exp=%h", m, CkRcbX2NB, ((m < 2) ? 4'hF : 4'h0)); end
                n_vec++; if (RcbEnAck !== 4'h0) begin n_err++; $display("FAIL ovr_ack m=%0d got=%h exp=0", m, RcbEnAck); end
                n_vec++; if (WakePend !== 1'b0) begin n_err++; $display("FAIL ovr_wake m=%0d got=%b exp=0", m, WakePend); end
            end
        end
    endtask

    task automatic test_reset_mid();
        HystCnt = 6'd10;
        RPEn = 4'h1;
        tick();
        RPEn = 4'h4;
        tick();
        n_vec++; if (RcbEnAck !== 4'h1 || WakePend !== 1'b1) begin n_err++; $display("FAIL mid_setup ack=%h wake=%b exp=1/1", RcbEnAck, WakePend); end
        RstB = 1'b0;
        #1;
        model_reset();
        n_vec++; if (RcbEnAck !== 4'h0) begin n_err++; $display("FAIL mid_async_ack got=%h exp=0", RcbEnAck); end
        n_vec++; if (WakePend !== 1'b0) begin n_err++; $display("FAIL mid_async_wake got=%b exp=0", WakePend); end
        #1;
        RstB = 1'b1;
        tick();
        n_vec++; if (RcbEnAck !== 4'h4) begin n_err++; $display("FAIL mid_regrant got=%h exp=4", RcbEnAck); end
        n_vec++; if (WakePend !== 1'b0) begin n_err++; $display("FAIL mid_regrant_wake got=%b exp=0", WakePend); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 3) == 0) RPEn[i] = ~RPEn[i];
            end
            if ($urandom_range(0, 7) == 0) HystCnt = HYST_W'($urandom_range(0, 6));
            RPOvrd         = ($urandom_range(0, 15) == 0);
            FscanClkUngate = ($urandom_range(0, 15) == 0);
            Fd = NUM_CH'($urandom);
            Rd = NUM_CH'($urandom);
            tick();
            n_vec++; if (RcbEnAck !== m_ack) begin n_err++; $display("FAIL rand_ack cyc=%0d got=%h exp=%h", c, RcbEnAck, m_ack); end
            n_vec++; if (WakePend !== m_wake) begin n_err++; $display("FAIL rand_wake cyc=%0d got=%b exp=%b", c, WakePend, m_wake); end
            n_vec++; if (CkRcbX2NB !== exp_ck()) begin n_err++; $display("FAIL rand_ck cyc=%0d got=%h exp=%h", c, CkRcbX2NB, exp_ck()); end
        end
    endtask

    initial begin
        test_reset();
        test_stagger();
        test_hold();
        test_reenter();
        test_override();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
